// File: rtl/shift_unit_pipelined.sv
// Pipelined barrel shifter: one register stage per shift-amount bit, with valid/ready
// handshake on both sides and a pass-through tag for matching results to requests.

module shift_unit_stage #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5,
  parameter int TAG_W = 5,
  parameter int STAGE = 0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             adv_i,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic [1:0]       mode_i,
  input  logic [SHW-1:0]   shamt_i,
  input  logic [TAG_W-1:0] tag_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic [1:0]       mode_o,
  output logic [SHW-1:0]   shamt_o,
  output logic [TAG_W-1:0] tag_o
);
  localparam int SH = 1 << STAGE;
  localparam logic [1:0] MODE_SLL = 2'b00;
  localparam logic [1:0] MODE_SRL = 2'b01;
  localparam logic [1:0] MODE_SRA = 2'b10;

  logic             valid_q;
  logic [WIDTH-1:0] data_q, data_d, shifted;
  logic [1:0]       mode_q;
  logic [SHW-1:0]   shamt_q;
  logic [TAG_W-1:0] tag_q;

  // SRA replicates the current MSB; earlier stages never disturb it, so it is the original sign.
  always_comb begin
    shifted = data_i;
    case (mode_i)
      MODE_SLL: shifted = data_i << SH;
      MODE_SRL: shifted = data_i >> SH;
      MODE_SRA: shifted = WIDTH'($signed(data_i) >>> SH);
      default:  shifted = (data_i << SH) | (data_i >> (WIDTH - SH));
    endcase
    data_d = shamt_i[STAGE] ? shifted : data_i;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      mode_q  <= '0;
      shamt_q <= '0;
      tag_q   <= '0;
    end else if (adv_i) begin
      valid_q <= valid_i;
      data_q  <= data_d;
      mode_q  <= mode_i;
      shamt_q <= shamt_i;
      tag_q   <= tag_i;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign mode_o  = mode_q;
  assign shamt_o = shamt_q;
  assign tag_o   = tag_q;
endmodule

module shift_unit_pipelined #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH),
  parameter int TAG_W = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_shamt,
  input  logic [1:0]       in_mode,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);
  localparam int L = SHW;

  logic [L-1:0]             v_q, adv, src_v;
  logic [L-1:0][WIDTH-1:0]  data_q, src_data;
  logic [L-1:0][1:0]        mode_q, src_mode;
  logic [L-1:0][SHW-1:0]    shamt_q, src_shamt;
  logic [L-1:0][TAG_W-1:0]  tag_q, src_tag;

  // A stage may advance unless it and every stage downstream are full and the sink is stalled.
  always_comb begin
    logic all_full;
    adv      = '0;
    all_full = 1'b1;
    for (int k = L - 1; k >= 0; k--) begin
      all_full = all_full & v_q[k];
      adv[k]   = !all_full | out_ready;
    end
  end

  for (genvar k = 0; k < L; k++) begin : g_stage
    if (k == 0) begin : g_head
      assign src_v[k]     = in_valid;
      assign src_data[k]  = in_data;
      assign src_mode[k]  = in_mode;
      assign src_shamt[k] = in_shamt;
      assign src_tag[k]   = in_tag;
    end else begin : g_link
      assign src_v[k]     = v_q[k-1];
      assign src_data[k]  = data_q[k-1];
      assign src_mode[k]  = mode_q[k-1];
      assign src_shamt[k] = shamt_q[k-1];
      assign src_tag[k]   = tag_q[k-1];
    end

    shift_unit_stage #(
      .WIDTH(WIDTH), .SHW(SHW), .TAG_W(TAG_W), .STAGE(k)
    ) u_stage (
      .clock   (clock),
      .reset   (reset),
      .adv_i   (adv[k]),
      .valid_i (src_v[k]),
      .data_i  (src_data[k]),
      .mode_i  (src_mode[k]),
      .shamt_i (src_shamt[k]),
      .tag_i   (src_tag[k]),
      .valid_o (v_q[k]),
      .data_o  (data_q[k]),
      .mode_o  (mode_q[k]),
      .shamt_o (shamt_q[k]),
      .tag_o   (tag_q[k])
    );
  end

  logic unused_tail;
  assign unused_tail = ^{mode_q[L-1], shamt_q[L-1]};

  assign in_ready  = adv[0];
  assign out_valid = v_q[L-1];
  assign out_data  = data_q[L-1];
  assign out_tag   = tag_q[L-1];
  assign busy      = |v_q;
endmodule

// File: doc/shift_unit_pipelined.md
# shift_unit_pipelined

Parametrised, pipelined barrel shifter for the ALU/execute path. It performs logical left, logical right, arithmetic right and rotate-left shifts on a WIDTH-bit operand. The block has one registered stage per shift-amount bit and a valid/ready handshake on both sides, so the datapath can stall it without losing operations. A tag field travels alongside each operation so the issuing logic can match results to requests.

## Interface
- WIDTH, 32: operand width; power of two, 4 to 64.
- SHW, $clog2(WIDTH): shift-amount width. Derived; do not override.
- TAG_W, 5: width of the pass-through tag.

Ports:
- clock  in  1  rising-edge clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  request present.
- in_ready  out  1  block can accept this cycle.
- in_data  in  WIDTH  operand.
- in_shamt  in  SHW  shift amount, unsigned.
- in_mode  in  2  00 SLL, 01 SRL, 10 SRA, 11 ROL.
- in_tag  in  TAG_W  opaque ID, returned unchanged.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts this cycle.
- out_data  out  WIDTH  shifted result.
- out_tag  out  TAG_W  tag of the result.
- busy  out  1  OR of all stage valid bits.

## Operation
- Pipeline depth L = SHW stages (L = 5 for WIDTH = 32).
- Stage k shifts by 2^k when the carried shamt bit k = 1, otherwise passes the value through. Stage 0 consumes the block inputs; stage k>0 consumes the stage k-1 register.
- Each stage register holds: valid, data, mode, the remaining shamt bits, and tag.
- Fill rules per stage:
  - SLL: zeros fill the vacated LSBs.
  - SRL: zeros fill the vacated MSBs.
  - SRA: copies of the current data MSB fill the vacated MSBs. This equals the original sign, because earlier stages preserve it.
  - ROL: bits leaving the MSB re-enter at the LSB.
- in_shamt = 0 returns in_data unchanged in every mode.
- Handshake transfer rules:
  - An input transfer occurs on a clock edge where in_valid & in_ready.
  - An output transfer occurs where out_valid & out_ready.
  - Inputs are ignored when in_valid = 0.
- Flow control, computed combinationally:
  - adv[L-1] = !v[L-1] | out_ready
  - adv[k] = !v[k] | adv[k+1]
  - in_ready = adv[0]
- A stage loads from its predecessor only when adv[k]. If the predecessor is invalid or not transferring, the stage's valid bit loads 0.
- Stall: a stage with v = 1 and adv = 0 holds its contents exactly. No data is dropped or duplicated.
- Outputs: out_valid = v[L-1]; out_data and out_tag come from stage L-1. When out_valid = 0, their values are don't-care.
- Reset:
  - All stage valid bits clear, giving out_valid = 0 and busy = 0.
  - Data and tag registers are also cleared to 0.
  - in_ready = 1 during and after reset.
  - Reset asserted mid-operation discards every in-flight operation. No result for them ever appears.

## Timing
- Latency: an operation accepted at edge N presents out_valid = 1 in the cycle following edge N+L-1, i.e. L cycles after the input cycle, provided there is no backpressure.
- Throughput: one operation per cycle when out_ready is held 1.
- Ready path: out_ready propagates combinationally to in_ready. Accepting an input in the same cycle as an output is consumed, with the pipeline full, is legal and required.
- Ordering: results emerge strictly in acceptance order.
- Occupancy: the pipeline holds at most L operations. When all stages are valid and out_ready = 0, in_ready = 0.
- No combinational path from in_* to out_*.

## Test plan
- Modes, WIDTH = 32, no stalls:
  - SLL 0x00000001 by 31 -> 0x80000000.
  - SRL 0x80000000 by 4 -> 0x08000000.
  - SRA 0x80000000 by 4 -> 0xF8000000.
  - ROL 0x80000001 by 1 -> 0x00000003.
  - Each result appears exactly 5 cycles after its input cycle, with its tag intact.
- Edge amounts: SRA 0x7FFFFFFF by 31 -> 0x00000000. SRA 0xFFFFFFFF by 31 -> 0xFFFFFFFF. Any mode by 0 -> operand unchanged.
- Back-to-back and backpressure:
  - Issue 8 operations on consecutive cycles (tags 0..7) with out_ready = 0 from cycle 3.
  - in_ready drops once 5 operations are held.
  - Release out_ready: all 8 results arrive in tag order, none lost or duplicated.
- Full-pipeline pass-through: with the pipeline full and out_ready = 1, in_valid held 1 -> one acceptance and one result every cycle, and in_ready stays 1.
- Reset mid-flight: assert reset for 1 cycle with 3 operations in flight -> out_valid = 0 and busy = 0 the next cycle; none of the 3 results ever appear; a new request afterwards completes with 5-cycle latency.
- Random compare: 10k random data/shamt/mode/tag values with random in_valid/out_ready -> every output matches the reference model, in order.
